// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: RV32I opcodes, one-hot ALU op and
// control-bit positions, and small helpers that build single-bit masks.
package decode_pkg;

  localparam int ALU_W  = 12;
  localparam int CTRL_W = 8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM2REG     = 1;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_MEM_READ    = 3;
  localparam int CTRL_BRANCH      = 4;
  localparam int CTRL_ALU_SRC_IMM = 5;
  localparam int CTRL_JUMP        = 6;
  localparam int CTRL_SRC1_PC     = 7;

  function automatic logic [ALU_W-1:0] alu_bit(input int idx);
    return ALU_W'(1) << idx;
  endfunction

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port. Contents are intentionally not reset; x0 is masked by the reader.
module regfile #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [RA_W-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RA_W-1:0] raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [RA_W-1:0] raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched word, reads/forwards operands,
// detects load-use (or, without forwarding, any EX/MEM RAW) hazards and
// registers the result toward EX.
//
// Handshake: fetch transfers when fs_valid & ds_ready on a rising edge; the
// output register transfers to EX when ds_valid & es_ready. While ds_valid is
// high and es_ready is low every output holds; flush squashes both sides.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int FWD_EN = 1,
  localparam int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fs_valid,
  input  logic [XLEN-1:0]   fs_pc,
  input  logic [31:0]       fs_inst,
  output logic              ds_ready,
  input  logic              flush,
  input  logic              es_ready,
  input  logic              es_valid,
  input  logic              es_reg_write,
  input  logic              es_is_load,
  input  logic [RA_W-1:0]   es_rd,
  input  logic [XLEN-1:0]   es_result,
  input  logic              ms_valid,
  input  logic              ms_reg_write,
  input  logic [RA_W-1:0]   ms_rd,
  input  logic [XLEN-1:0]   ms_result,
  input  logic              ws_wen,
  input  logic [RA_W-1:0]   ws_waddr,
  input  logic [XLEN-1:0]   ws_wdata,
  output logic              ds_valid,
  output logic [XLEN-1:0]   ds_pc,
  output logic [XLEN-1:0]   ds_src1,
  output logic [XLEN-1:0]   ds_src2,
  output logic [XLEN-1:0]   ds_imm,
  output logic [RA_W-1:0]   ds_rd,
  output logic [ALU_W-1:0]  ds_alu_op,
  output logic [CTRL_W-1:0] ds_ctrl,
  output logic              ds_illegal
);

  localparam bit FWD = (FWD_EN != 0);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic [RA_W-1:0] rs_a [2];
  logic [RA_W-1:0] rd;

  assign opcode  = fs_inst[6:0];
  assign rd_f    = fs_inst[11:7];
  assign funct3  = fs_inst[14:12];
  assign rs1_f   = fs_inst[19:15];
  assign rs2_f   = fs_inst[24:20];
  assign funct7  = fs_inst[31:25];
  assign rs_a[0] = rs1_f[RA_W-1:0];
  assign rs_a[1] = rs2_f[RA_W-1:0];
  assign rd      = rd_f[RA_W-1:0];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{fs_inst[31]}}, fs_inst[31:20]};
  assign imm_s = {{20{fs_inst[31]}}, fs_inst[31:25], fs_inst[11:7]};
  assign imm_b = {{19{fs_inst[31]}}, fs_inst[31], fs_inst[7], fs_inst[30:25], fs_inst[11:8], 1'b0};
  assign imm_u = {fs_inst[31:12], 12'b0};
  assign imm_j = {{11{fs_inst[31]}}, fs_inst[31], fs_inst[19:12], fs_inst[20], fs_inst[30:21], 1'b0};

  logic [ALU_W-1:0]  alu_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [31:0]       imm32;
  logic [1:0]        use_rs;
  logic              illegal_d;

  always_comb begin
    alu_d     = '0;
    ctrl_d    = '0;
    imm32     = '0;
    use_rs    = 2'b00;
    illegal_d = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        alu_d  = alu_bit(ALU_LUI);
        ctrl_d = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_ALU_SRC_IMM);
        imm32  = imm_u;
      end
      OPC_AUIPC: begin
        alu_d  = alu_bit(ALU_ADD);
        ctrl_d = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_ALU_SRC_IMM) | ctrl_bit(CTRL_SRC1_PC);
        imm32  = imm_u;
      end
      OPC_JAL: begin
        alu_d  = alu_bit(ALU_ADD);
        ctrl_d = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_ALU_SRC_IMM) | ctrl_bit(CTRL_JUMP)
               | ctrl_bit(CTRL_SRC1_PC);
        imm32  = imm_j;
      end
      OPC_JALR: begin
        alu_d     = alu_bit(ALU_ADD);
        ctrl_d    = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_ALU_SRC_IMM) | ctrl_bit(CTRL_JUMP);
        imm32     = imm_i;
        use_rs    = 2'b01;
        illegal_d = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_d = ctrl_bit(CTRL_BRANCH);
        imm32  = imm_b;
        use_rs = 2'b11;
        unique case (funct3)
          3'b000, 3'b001: alu_d = alu_bit(ALU_SUB);
          3'b100, 3'b101: alu_d = alu_bit(ALU_SLT);
          3'b110, 3'b111: alu_d = alu_bit(ALU_SLTU);
          default:        illegal_d = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        alu_d     = alu_bit(ALU_ADD);
        ctrl_d    = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_MEM2REG) | ctrl_bit(CTRL_MEM_READ)
                  | ctrl_bit(CTRL_ALU_SRC_IMM);
        imm32     = imm_i;
        use_rs    = 2'b01;
        illegal_d = (funct3 != 3'b010);
      end
      OPC_STORE: begin
        alu_d     = alu_bit(ALU_ADD);
        ctrl_d    = ctrl_bit(CTRL_MEM_WRITE) | ctrl_bit(CTRL_ALU_SRC_IMM);
        imm32     = imm_s;
        use_rs    = 2'b11;
        illegal_d = (funct3 != 3'b010);
      end
      OPC_OPIMM: begin
        ctrl_d = ctrl_bit(CTRL_REG_WRITE) | ctrl_bit(CTRL_ALU_SRC_IMM);
        imm32  = imm_i;
        use_rs = 2'b01;
        unique case (funct3)
          3'b000: alu_d = alu_bit(ALU_ADD);
          3'b010: alu_d = alu_bit(ALU_SLT);
          3'b011: alu_d = alu_bit(ALU_SLTU);
          3'b100: alu_d = alu_bit(ALU_XOR);
          3'b110: alu_d = alu_bit(ALU_OR);
          3'b111: alu_d = alu_bit(ALU_AND);
          3'b001: if (funct7 == 7'b0000000) alu_d = alu_bit(ALU_SLL); else illegal_d = 1'b1;
          default: begin
            if (funct7 == 7'b0000000)      alu_d = alu_bit(ALU_SRL);
            else if (funct7 == 7'b0100000) alu_d = alu_bit(ALU_SRA);
            else                           illegal_d = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        ctrl_d = ctrl_bit(CTRL_REG_WRITE);
        use_rs = 2'b11;
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000: alu_d = alu_bit(ALU_ADD);
            3'b001: alu_d = alu_bit(ALU_SLL);
            3'b010: alu_d = alu_bit(ALU_SLT);
            3'b011: alu_d = alu_bit(ALU_SLTU);
            3'b100: alu_d = alu_bit(ALU_XOR);
            3'b101: alu_d = alu_bit(ALU_SRL);
            3'b110: alu_d = alu_bit(ALU_OR);
            default: alu_d = alu_bit(ALU_AND);
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_d = alu_bit(ALU_SUB);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          alu_d = alu_bit(ALU_SRA);
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
    // An illegal word behaves as a bubble-like no-op with no side effects.
    if (illegal_d) begin
      alu_d  = '0;
      ctrl_d = '0;
      imm32  = '0;
      use_rs = 2'b00;
    end
    if (rd_f == 5'd0) ctrl_d = ctrl_d & ~ctrl_bit(CTRL_REG_WRITE);
  end

  logic [XLEN-1:0] rf_rdata [2];

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .we_i     (ws_wen),
    .waddr_i  (ws_waddr),
    .wdata_i  (ws_wdata),
    .raddr1_i (rs_a[0]),
    .rdata1_o (rf_rdata[0]),
    .raddr2_i (rs_a[1]),
    .rdata2_o (rf_rdata[1])
  );

  logic [1:0] used_nz, ex_hit, mem_hit, wb_hit, load_hit;
  logic       hazard;
  logic [XLEN-1:0] src_val [2];

  for (genvar s = 0; s < 2; s++) begin : g_src
    assign used_nz[s]  = use_rs[s] & (rs_a[s] != '0);
    assign ex_hit[s]   = es_valid & es_reg_write & (es_rd == rs_a[s]);
    assign load_hit[s] = es_valid & es_is_load & (es_rd == rs_a[s]);
    assign mem_hit[s]  = ms_valid & ms_reg_write & (ms_rd == rs_a[s]);
    assign wb_hit[s]   = ws_wen & (ws_waddr == rs_a[s]);

    // A load in EX never forwards: its data is not ready until MEM.
    always_comb begin
      src_val[s] = '0;
      if (used_nz[s]) begin
        if (FWD && ex_hit[s] && !es_is_load) src_val[s] = es_result;
        else if (FWD && mem_hit[s])          src_val[s] = ms_result;
        else if (wb_hit[s])                  src_val[s] = ws_wdata;
        else                                 src_val[s] = rf_rdata[s];
      end
    end
  end

  assign hazard = fs_valid & (|(used_nz & (load_hit | (FWD ? 2'b00 : (ex_hit | mem_hit)))));

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, src1_q, src2_q, imm_q;
  logic [RA_W-1:0]   rd_q;
  logic [ALU_W-1:0]  alu_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              illegal_q;

  assign ds_ready = (~fs_valid | ~hazard) & (~valid_q | es_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fs_valid && ds_ready) begin
      valid_q   <= 1'b1;
      pc_q      <= fs_pc;
      src1_q    <= src_val[0];
      src2_q    <= src_val[1];
      imm_q     <= XLEN'($signed(imm32));
      rd_q      <= rd;
      alu_q     <= alu_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end else if (!valid_q || es_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ds_valid   = valid_q;
  assign ds_pc      = pc_q;
  assign ds_src1    = src1_q;
  assign ds_src2    = src2_q;
  assign ds_imm     = imm_q;
  assign ds_rd      = rd_q;
  assign ds_alu_op  = alu_q;
  assign ds_ctrl    = ctrl_q;
  assign ds_illegal = illegal_q;

endmodule
